// File: rtl/ram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ram_ctrl_pkg
// Shared definitions for the two-requester RAM controller.
//   DEPTH / AW / DW : RAM geometry (16 words x 8 bits, 4-bit requester address)
//   RAM_AW          : width of the RAM address pins (one spare MSB, always 0)
//   state_t         : controller FSM state (INIT clears the RAM, RUN serves)
//   req_id_t        : identifies which requester a transaction belongs to
//   ram_addr_ext    : zero-extends a requester address onto the RAM pins
// ---------------------------------------------------------------------------
package ram_ctrl_pkg;

  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int DW     = 8;
  localparam int RAM_AW = 5;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef logic req_id_t;

  function automatic logic [RAM_AW-1:0] ram_addr_ext(input logic [AW-1:0] a);
    return RAM_AW'(a);
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter.
//   clk, rst  : clock, asynchronous active-low reset
//   req[1:0]  : request per requester
//   en        : arbitration allowed this cycle
//   gnt[1:0]  : combinational grant, one-hot or zero
// The priority pointer names the requester that wins a tie; after any grant
// it moves to the other requester.
// ---------------------------------------------------------------------------
module rr_arb2
  import ram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  req_id_t    r_ptr;
  logic [1:0] w_gnt;

  always_comb begin
    w_gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
        2'b11:   w_gnt = r_ptr ? 2'b10 : 2'b01;
        default: w_gnt = 2'b00;
      endcase
    end
  end

  // Whoever was just served loses priority: a grant to 0 points at 1 and
  // vice versa, so the new pointer is simply the bit "requester 0 won".
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= 1'b0;
    end else if (|w_gnt) begin
      r_ptr <= w_gnt[0];
    end
  end

  assign gnt = w_gnt;

endmodule

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Controller between two client blocks and a 16x8 single-clock RAM.
// After reset it clears every RAM word, then serves requester 0 and 1 with
// round-robin arbitration, one access per cycle.
//   clk, rst                 : clock, asynchronous active-low reset
//   req_x/we_x/addr_x/wdata_x: requester x command, held until gnt_x
//   gnt_x                    : combinational accept for requester x
//   rvalid_x                 : one-cycle strobe, rdata belongs to requester x
//   rdata                    : shared read data (straight from ram_r_data)
//   init_done                : clear sequence finished
//   ram_enb/wr/rd, ram_w_addr, ram_r_addr, ram_w_data : registered RAM command
//   ram_r_data               : RAM read data, one edge after ram_rd sampled
// ---------------------------------------------------------------------------
module ram_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_0,
  input  logic              req_1,
  input  logic              we_0,
  input  logic              we_1,
  input  logic [AW-1:0]     addr_0,
  input  logic [AW-1:0]     addr_1,
  input  logic [DW-1:0]     wdata_0,
  input  logic [DW-1:0]     wdata_1,
  output logic              gnt_0,
  output logic              gnt_1,
  output logic              rvalid_0,
  output logic              rvalid_1,
  output logic [DW-1:0]     rdata,
  output logic              init_done,
  output logic              ram_enb,
  output logic              ram_wr,
  output logic              ram_rd,
  output logic [RAM_AW-1:0] ram_w_addr,
  output logic [RAM_AW-1:0] ram_r_addr,
  output logic [DW-1:0]     ram_w_data,
  input  logic [DW-1:0]     ram_r_data
);

  localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

  state_t              r_state;
  logic [AW-1:0]       r_cnt;
  logic                r_init_done;
  logic                r_ram_enb;
  logic                r_ram_wr;
  logic                r_ram_rd;
  logic [RAM_AW-1:0]   r_ram_w_addr;
  logic [RAM_AW-1:0]   r_ram_r_addr;
  logic [DW-1:0]       r_ram_w_data;

  logic                r_vld_p0;
  req_id_t             r_id_p0;
  logic                r_vld_p1;
  req_id_t             r_id_p1;

  logic [1:0]          w_gnt;
  logic                w_any_gnt;
  req_id_t             w_sel_id;
  logic                w_sel_we;
  logic [AW-1:0]       w_sel_addr;
  logic [DW-1:0]       w_sel_wdata;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({req_1, req_0}),
    .en  (r_state == RUN),
    .gnt (w_gnt)
  );

  // Mux the winning requester's command; gnt is one-hot so bit 1 is the id.
  assign w_any_gnt   = |w_gnt;
  assign w_sel_id    = w_gnt[1];
  assign w_sel_we    = w_sel_id ? we_1    : we_0;
  assign w_sel_addr  = w_sel_id ? addr_1  : addr_0;
  assign w_sel_wdata = w_sel_id ? wdata_1 : wdata_0;

  // ---- command stage: FSM and registered RAM pins ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= INIT;
      r_cnt        <= '0;
      r_init_done  <= 1'b0;
      r_ram_enb    <= 1'b0;
      r_ram_wr     <= 1'b0;
      r_ram_rd     <= 1'b0;
      r_ram_w_addr <= '0;
      r_ram_r_addr <= '0;
      r_ram_w_data <= '0;
    end else begin
      case (r_state)
        INIT: begin
          r_ram_enb    <= 1'b1;
          r_ram_wr     <= 1'b1;
          r_ram_rd     <= 1'b0;
          r_ram_w_addr <= ram_addr_ext(r_cnt);
          r_ram_r_addr <= '0;
          r_ram_w_data <= '0;
          r_cnt        <= r_cnt + 1'b1;
          // init_done rises with the last clear command, so a grant can be
          // accepted on the very next edge.
          if (r_cnt == CNT_LAST) begin
            r_state     <= RUN;
            r_init_done <= 1'b1;
            r_cnt       <= '0;
          end
        end
        RUN: begin
          if (w_any_gnt) begin
            r_ram_enb <= 1'b1;
            r_ram_wr  <= w_sel_we;
            r_ram_rd  <= !w_sel_we;
            if (w_sel_we) begin
              r_ram_w_addr <= ram_addr_ext(w_sel_addr);
              r_ram_w_data <= w_sel_wdata;
              r_ram_r_addr <= '0;
            end else begin
              r_ram_r_addr <= ram_addr_ext(w_sel_addr);
              r_ram_w_addr <= '0;
              r_ram_w_data <= '0;
            end
          end else begin
            r_ram_enb    <= 1'b0;
            r_ram_wr     <= 1'b0;
            r_ram_rd     <= 1'b0;
            r_ram_w_addr <= '0;
            r_ram_r_addr <= '0;
            r_ram_w_data <= '0;
          end
        end
        default: begin
          r_state <= INIT;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // ---- read return stage p0: read accepted, command on the RAM pins ----
  // ---- read return stage p1: RAM has registered the data ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_p0 <= 1'b0;
      r_id_p0  <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_id_p1  <= 1'b0;
    end else begin
      r_vld_p0 <= w_any_gnt && !w_sel_we;
      r_id_p0  <= w_sel_id;
      r_vld_p1 <= r_vld_p0;
      r_id_p1  <= r_id_p0;
    end
  end

  assign gnt_0      = w_gnt[0];
  assign gnt_1      = w_gnt[1];
  assign rvalid_0   = r_vld_p1 && (r_id_p1 == 1'b0);
  assign rvalid_1   = r_vld_p1 && (r_id_p1 == 1'b1);
  assign rdata      = ram_r_data;
  assign init_done  = r_init_done;
  assign ram_enb    = r_ram_enb;
  assign ram_wr     = r_ram_wr;
  assign ram_rd     = r_ram_rd;
  assign ram_w_addr = r_ram_w_addr;
  assign ram_r_addr = r_ram_r_addr;
  assign ram_w_data = r_ram_w_data;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_0 = 1'b0, req_1 = 1'b0;
  logic       we_0 = 1'b0, we_1 = 1'b0;
  logic [3:0] addr_0 = '0, addr_1 = '0;
  logic [7:0] wdata_0 = '0, wdata_1 = '0;
  logic       gnt_0, gnt_1, rvalid_0, rvalid_1, init_done;
  logic [7:0] rdata;
  logic       ram_enb, ram_wr, ram_rd;
  logic [4:0] ram_w_addr, ram_r_addr;
  logic [7:0] ram_w_data;
  logic [7:0] ram_r_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .rst(rst),
    .req_0(req_0), .req_1(req_1), .we_0(we_0), .we_1(we_1),
    .addr_0(addr_0), .addr_1(addr_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
    .rdata(rdata), .init_done(init_done),
    .ram_enb(ram_enb), .ram_wr(ram_wr), .ram_rd(ram_rd),
    .ram_w_addr(ram_w_addr), .ram_r_addr(ram_r_addr), .ram_w_data(ram_w_data),
    .ram_r_data(ram_r_data)
  );

  // 16x8 RAM model: contents survive reset, read data registered.
  logic [7:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = 8'hF0 | 8'(i);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_r_data <= '0;
    end else begin
      if (ram_enb && ram_wr) mem[ram_w_addr[3:0]] <= ram_w_data;
      if (ram_enb && ram_rd) ram_r_data <= mem[ram_r_addr[3:0]];
    end
  end

  wire [33:0] w_all_out = {gnt_0, gnt_1, rvalid_0, rvalid_1, init_done, ram_enb, ram_wr,
                           ram_rd, ram_w_addr, ram_r_addr, ram_w_data, rdata};
  wire [1:0]  w_gnt = {gnt_1, gnt_0};
  wire [2:0]  w_cmd = {ram_enb, ram_wr, ram_rd};

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    req_0 = 1'b0; req_1 = 1'b0; we_0 = 1'b0; we_1 = 1'b0;
  endtask

  task automatic test_reset();
    logic exp_done;
    rst = 1'b0;
    idle();
    tick(); tick();
    n_checks++;
    if (w_all_out !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", w_all_out);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (w_gnt !== 2'b00) begin
      n_fail++; $display("FAIL init_no_gnt: got %b expected 00", w_gnt);
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_done = (i == 15);
      n_checks++;
      if (w_cmd !== 3'b110 || ram_w_addr !== 5'(i) || ram_w_data !== 8'h00 || init_done !== exp_done) begin
        n_fail++;
        $display("FAIL clear_cmd[%0d]: got cmd=%b waddr=%0d wdata=%h done=%b expected cmd=110 waddr=%0d wdata=00 done=%b",
                 i, w_cmd, ram_w_addr, ram_w_data, init_done, i, exp_done);
      end
    end
    req_0 = 1'b1; we_0 = 1'b0; addr_0 = 4'd7;
    #1;
    n_checks++;
    if (w_gnt !== 2'b01) begin
      n_fail++; $display("FAIL first_read_gnt: got %b expected 01", w_gnt);
    end
    tick();
    idle();
    n_checks++;
    if (w_cmd !== 3'b101 || ram_r_addr !== 5'd7 || rvalid_0 !== 1'b0) begin
      n_fail++; $display("FAIL read7_cmd: got cmd=%b raddr=%0d rv0=%b expected 101/7/0", w_cmd, ram_r_addr, rvalid_0);
    end
    tick();
    n_checks++;
    if (rvalid_0 !== 1'b1 || rvalid_1 !== 1'b0 || rdata !== 8'h00) begin
      n_fail++; $display("FAIL read7_data: got rv0=%b rv1=%b rdata=%h expected 1/0/00", rvalid_0, rvalid_1, rdata);
    end
    tick();
    n_checks++;
    if (rvalid_0 !== 1'b0) begin
      n_fail++; $display("FAIL read7_strobe_len: got rv0=%b expected 0", rvalid_0);
    end
  endtask

  task automatic test_write_then_read();
    req_0 = 1'b1; we_0 = 1'b1; addr_0 = 4'd3; wdata_0 = 8'hA5;
    #1;
    n_checks++;
    if (w_gnt !== 2'b01) begin
      n_fail++; $display("FAIL wr3_gnt: got %b expected 01", w_gnt);
    end
    tick();
    idle();
    req_1 = 1'b1; we_1 = 1'b0; addr_1 = 4'd3;
    n_checks++;
    if (w_cmd !== 3'b110 || ram_w_addr !== 5'd3 || ram_w_data !== 8'hA5) begin
      n_fail++; $display("FAIL wr3_cmd: got cmd=%b waddr=%0d wdata=%h expected 110/3/a5", w_cmd, ram_w_addr, ram_w_data);
    end
    #1;
    n_checks++;
    if (w_gnt !== 2'b10) begin
      n_fail++; $display("FAIL rd3_gnt: got %b expected 10", w_gnt);
    end
    tick();
    idle();
    n_checks++;
    if (w_cmd !== 3'b101 || ram_r_addr !== 5'd3) begin
      n_fail++; $display("FAIL rd3_cmd: got cmd=%b raddr=%0d expected 101/3", w_cmd, ram_r_addr);
    end
    tick();
    n_checks++;
    if (rvalid_1 !== 1'b1 || rvalid_0 !== 1'b0 || rdata !== 8'hA5) begin
      n_fail++; $display("FAIL rd3_data: got rv1=%b rv0=%b rdata=%h expected 1/0/a5", rvalid_1, rvalid_0, rdata);
    end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_g;
    logic       exp_rv0;
    req_0 = 1'b1; we_0 = 1'b0; addr_0 = 4'd4;
    req_1 = 1'b1; we_1 = 1'b0; addr_1 = 4'd5;
    for (int i = 0; i < 6; i++) begin
      #1;
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      n_checks++;
      if (w_gnt !== exp_g) begin
        n_fail++; $display("FAIL alt_gnt[%0d]: got %b expected %b", i, w_gnt, exp_g);
      end
      tick();
      if (i == 5) idle();
      n_checks++;
      if (w_cmd !== 3'b101 || ram_r_addr !== ((i % 2 == 0) ? 5'd4 : 5'd5)) begin
        n_fail++; $display("FAIL alt_cmd[%0d]: got cmd=%b raddr=%0d", i, w_cmd, ram_r_addr);
      end
      if (i >= 1) begin
        exp_rv0 = ((i - 1) % 2 == 0);
        n_checks++;
        if (rvalid_0 !== exp_rv0 || rvalid_1 !== !exp_rv0) begin
          n_fail++; $display("FAIL alt_rvalid[%0d]: got rv0=%b rv1=%b expected rv0=%b", i, rvalid_0, rvalid_1, exp_rv0);
        end
      end
    end
    tick();
    n_checks++;
    if (rvalid_1 !== 1'b1 || rvalid_0 !== 1'b0 || w_cmd !== 3'b000) begin
      n_fail++; $display("FAIL alt_tail: got rv1=%b rv0=%b cmd=%b expected 1/0/000", rvalid_1, rvalid_0, w_cmd);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    req_0 = 1'b1; we_0 = 1'b1; addr_0 = 4'd1; wdata_0 = 8'h11;
    tick();
    idle();
    req_1 = 1'b1; we_1 = 1'b1; addr_1 = 4'd2; wdata_1 = 8'h22;
    tick();
    idle();
    req_0 = 1'b1; we_0 = 1'b1; addr_0 = 4'd3; wdata_0 = 8'h33;
    tick();
    idle();
    req_0 = 1'b1; we_0 = 1'b0; addr_0 = 4'd1;
    #1;
    n_checks++;
    if (w_gnt !== 2'b01) begin
      n_fail++; $display("FAIL b2b_gnt_a: got %b expected 01", w_gnt);
    end
    tick();
    idle();
    req_1 = 1'b1; we_1 = 1'b0; addr_1 = 4'd2;
    #1;
    n_checks++;
    if (w_gnt !== 2'b10) begin
      n_fail++; $display("FAIL b2b_gnt_b: got %b expected 10", w_gnt);
    end
    tick();
    idle();
    req_0 = 1'b1; we_0 = 1'b0; addr_0 = 4'd3;
    n_checks++;
    if (rvalid_0 !== 1'b1 || rvalid_1 !== 1'b0 || rdata !== 8'h11) begin
      n_fail++; $display("FAIL b2b_rd_a: got rv0=%b rv1=%b rdata=%h expected 1/0/11", rvalid_0, rvalid_1, rdata);
    end
    tick();
    idle();
    n_checks++;
    if (rvalid_1 !== 1'b1 || rvalid_0 !== 1'b0 || rdata !== 8'h22) begin
      n_fail++; $display("FAIL b2b_rd_b: got rv0=%b rv1=%b rdata=%h expected 0/1/22", rvalid_0, rvalid_1, rdata);
    end
    tick();
    n_checks++;
    if (rvalid_0 !== 1'b1 || rvalid_1 !== 1'b0 || rdata !== 8'h33) begin
      n_fail++; $display("FAIL b2b_rd_c: got rv0=%b rv1=%b rdata=%h expected 1/0/33", rvalid_0, rvalid_1, rdata);
    end
    tick();
    n_checks++;
    if (rvalid_0 !== 1'b0 || rvalid_1 !== 1'b0) begin
      n_fail++; $display("FAIL b2b_tail: got rv0=%b rv1=%b expected 0/0", rvalid_0, rvalid_1);
    end
  endtask

  task automatic test_requests_during_init();
    rst = 1'b0;
    req_0 = 1'b1; we_0 = 1'b0; addr_0 = 4'd1;
    req_1 = 1'b1; we_1 = 1'b0; addr_1 = 4'd2;
    #1;
    n_checks++;
    if (w_all_out !== '0) begin
      n_fail++; $display("FAIL rerun_reset_outputs: got %h expected 0", w_all_out);
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      #1;
      if (i < 15) begin
        n_checks++;
        if (w_gnt !== 2'b00 || init_done !== 1'b0) begin
          n_fail++; $display("FAIL init_hold[%0d]: got gnt=%b done=%b expected 00/0", i, w_gnt, init_done);
        end
      end else begin
        n_checks++;
        if (w_gnt !== 2'b01 || init_done !== 1'b1) begin
          n_fail++; $display("FAIL init_first_gnt: got gnt=%b done=%b expected 01/1", w_gnt, init_done);
        end
      end
    end
    tick();
    #1;
    n_checks++;
    if (w_gnt !== 2'b10) begin
      n_fail++; $display("FAIL init_second_gnt: got %b expected 10", w_gnt);
    end
    tick();
    idle();
    n_checks++;
    if (rvalid_0 !== 1'b1 || rdata !== 8'h00) begin
      n_fail++; $display("FAIL reclear_addr1: got rv0=%b rdata=%h expected 1/00", rvalid_0, rdata);
    end
    tick();
    n_checks++;
    if (rvalid_1 !== 1'b1 || rdata !== 8'h00) begin
      n_fail++; $display("FAIL reclear_addr2: got rv1=%b rdata=%h expected 1/00", rvalid_1, rdata);
    end
    tick();
  endtask

  task automatic test_reset_inflight();
    int k;
    req_0 = 1'b1; we_0 = 1'b1; addr_0 = 4'd5; wdata_0 = 8'h5A;
    tick();
    idle();
    req_0 = 1'b1; we_0 = 1'b0; addr_0 = 4'd5;
    tick();
    idle();
    n_checks++;
    if (w_cmd !== 3'b101 || ram_r_addr !== 5'd5) begin
      n_fail++; $display("FAIL inflight_cmd: got cmd=%b raddr=%0d expected 101/5", w_cmd, ram_r_addr);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (w_all_out !== '0) begin
      n_fail++; $display("FAIL inflight_reset_outputs: got %h expected 0", w_all_out);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (rvalid_0 !== 1'b0 || rvalid_1 !== 1'b0) begin
        n_fail++; $display("FAIL inflight_dropped[%0d]: got rv0=%b rv1=%b expected 0/0", i, rvalid_0, rvalid_1);
      end
    end
    rst = 1'b1;
    k = 0;
    while (init_done !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    n_checks++;
    if (init_done !== 1'b1 || k != 16) begin
      n_fail++; $display("FAIL inflight_reinit: got done=%b after %0d cycles expected 1 after 16", init_done, k);
    end
    req_0 = 1'b1; we_0 = 1'b0; addr_0 = 4'd5;
    tick();
    idle();
    tick();
    n_checks++;
    if (rvalid_0 !== 1'b1 || rdata !== 8'h00) begin
      n_fail++; $display("FAIL inflight_readback: got rv0=%b rdata=%h expected 1/00", rvalid_0, rdata);
    end
    tick();
  endtask

  // Guard: ram_wr and ram_rd must never be active together.
  always @(negedge clk) begin
    if (rst && ram_wr && ram_rd) begin
      n_fail++;
      $display("FAIL wr_rd_exclusive: got wr=1 rd=1 expected not both");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_write_then_read();
    test_alternate();
    test_back_to_back();
    test_requests_during_init();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester controller for the 16×8 single-clock RAM. After reset it runs a clear sequence that writes zero to every location; it then shares the RAM between requester 0 and requester 1 with round-robin arbitration, one access per cycle. It drives the RAM command pins from registers and returns read data with a per-requester valid strobe. It sits directly between the two client blocks and the RAM instance.

## Interface
Parameters:
- DEPTH, 16: RAM words; also the length of the clear sequence.
- AW, 4: requester address width (log2 DEPTH).
- DW, 8: data width.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- rst  in  1  reset, asynchronous, active-low. Also wired to the RAM's rst at top level.
- req_0, req_1  in  1  access request; held with we/addr/wdata until granted.
- we_0, we_1  in  1  1 = write, 0 = read.
- addr_0, addr_1  in  AW  word address.
- wdata_0, wdata_1  in  DW  write data.
- gnt_0, gnt_1  out  1  combinational accept; request is consumed at this edge.
- rvalid_0, rvalid_1  out  1  one-cycle strobe: rdata valid for that requester's read.
- rdata  out  DW  shared read data, equal to ram_r_data.
- init_done  out  1  clear sequence finished; grants are possible.
- ram_enb, ram_wr, ram_rd  out  1  RAM command, registered.
- ram_w_addr, ram_r_addr  out  5  RAM addresses, registered. Requester address is zero-extended, so bit 4 is always 0.
- ram_w_data  out  DW  RAM write data, registered.
- ram_r_data  in  DW  RAM read data. The RAM registers it one edge after ram_rd is sampled.

## Operation
- FSM states: INIT and RUN. Reset enters INIT with cnt=0.
- INIT:
  - Each cycle, register ram_enb=1, ram_wr=1, ram_rd=0, ram_w_addr=cnt, ram_w_data=0, then cnt++.
  - After issuing cnt=DEPTH-1, go to RUN; init_done is registered high from that edge on.
  - gnt_x=0 throughout INIT; requests stay pending.
- RUN arbitration:
  - If only one requester has req high, it gets gnt.
  - If both are high, grant the one indicated by priority pointer ptr (reset 0). After any grant, ptr becomes the other requester.
  - At most one gnt per cycle.
- Granted write: register ram_enb=1, ram_wr=1, ram_rd=0, ram_w_addr={0,addr}, ram_w_data=wdata.
- Granted read: register ram_enb=1, ram_rd=1, ram_wr=0, ram_r_addr={0,addr}.
- No grant: ram_enb, ram_wr, ram_rd, both addresses and ram_w_data all register to 0.
- ram_wr and ram_rd are never both 1.
- Read return: a 2-stage pipeline carries (is_read, id). rvalid_id pulses when the data reaches ram_r_data.

## Timing
- Reset values: every output is 0, including init_done, gnt, rvalid and all ram_* outputs. ptr=0, cnt=0, read pipeline cleared.
- INIT takes exactly DEPTH cycles of write commands. The first command is registered at the first clk edge after rst deasserts. init_done=1 in the cycle after the last clear command.
- Accept edge E0 (req & gnt high): the command is on the ram_* pins during cycle E0→E1.
  - Write takes effect in memory at E1.
  - Read: ram_r_data updates at E1; rvalid_x=1 and rdata valid during E1→E2. Read latency is 2 edges from accept.
- Throughput: one access per cycle. Back-to-back reads give back-to-back rvalid pulses in grant order.
- Write at E0, then read of the same address accepted at E1: the read returns the new data, because the write lands at E1 and the read samples at E2.
- Reset mid-operation: immediately clears the FSM, ptr and pipeline; in-flight rvalid pulses are dropped; INIT restarts after deassertion.
- req falling without a gnt is legal; the request is simply withdrawn.

## Structure
- Package ram_ctrl_pkg holds:
  - DEPTH, AW, DW and RAM_AW=5;
  - the state enum {INIT, RUN};
  - a request id type (1 bit).
- Sub-module rr_arb2 is the 2-way round-robin arbiter: inputs req[1:0] and en; outputs gnt[1:0] one-hot or zero; owns ptr.
- The rest (INIT counter, command registers, read pipeline) stays in ram_arbiter.

## Test plan
- Reset, then release: 16 consecutive writes to addresses 0..15 with data 0, then init_done=1. A read of addr 7 returns 0 with rvalid at accept+2.
- RUN, requester 0 writes addr 3 = 0xA5, then requester 1 reads addr 3 the next cycle: rvalid_1=1, rdata=0xA5 at that read's accept+2.
- req_0 and req_1 held high for 6 cycles: grants alternate 0,1,0,1,0,1. Exactly one gnt per cycle; ram_wr and ram_rd are never both 1.
- Requests asserted during INIT: no gnt until init_done=1. Both pending, so requester 0 is granted first.
- Back-to-back reads r0@addr1, r1@addr2, r0@addr3 after writing 0x11/0x22/0x33: rvalid_0, rvalid_1, rvalid_0 on consecutive cycles with rdata 0x11, 0x22, 0x33.
- rst asserted while a read is in flight: rvalid never pulses; all outputs 0 immediately; INIT reruns and the memory reads back 0.
